perceptron_frame_ctrl: RTL and testbench



---
 rtl/perceptron_pkg.sv | 22 ++
 rtl/perceptron_frame_ctrl_if.sv | 22 ++
 rtl/perceptron_frame_ctrl_frame_deser.sv | 30 +++
 rtl/perceptron_frame_ctrl.sv | 104 ++++++++++
 tb/tb_perceptron_frame_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants for the perceptron classifier and its frame controller:
// class codes, controller FSM encoding and classifier reference sums.
package perceptron_pkg;

   localparam logic [1:0] CLASS_NONE    = 2'b00;
   localparam logic [1:0] CLASS_CIRCLE  = 2'b01;
   localparam logic [1:0] CLASS_CROSS   = 2'b10;
   localparam logic [1:0] CLASS_TIMEOUT = 2'b11;

   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

   localparam int CIRCLE_SUM_VAL = 4;
   localparam int CROSS_SUM_VAL  = 11;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/perceptron_frame_ctrl_if.sv
// Pixel-stream and result handshakes of the perceptron frame controller.
// master = pixel source / result consumer, slave = controller.
interface perceptron_frame_ctrl_if;

   logic       pix_data;
   logic       pix_valid;
   logic       pix_ready;
   logic [1:0] res_class;
   logic       res_valid;
   logic       res_ack;

   modport master (
      output pix_data, pix_valid, res_ack,
      input  pix_ready, res_class, res_valid
   );

   modport slave (
      input  pix_data, pix_valid, res_ack,
      output pix_ready, res_class, res_valid
   );

endinterface

// File: rtl/perceptron_frame_ctrl_frame_deser.sv
// Bit-serial to WIDTH-bit frame register; first beat lands in bit 0.
// done pulses combinationally on the beat that completes the frame.
module frame_deser #(
   parameter int WIDTH = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             beat,
   output logic [WIDTH-1:0] frame,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] cnt;

   assign done = beat && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame <= '0;
         cnt   <= '0;
      end else if (beat) begin
         frame[cnt] <= bit_in;
         cnt        <= done ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/perceptron_frame_ctrl.sv
// Frame controller driving the serial-MAC perceptron classifier.
// Define PERC_CTRL_STATS_EN to add saturating per-class result counters.
module perceptron_frame_ctrl
   import perceptron_pkg::*;
#(
   parameter int WIDTH   = 25,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   perceptron_frame_ctrl_if.slave bus,
   output logic [WIDTH-1:0] p_in,
   output logic             p_en,
   input  logic [1:0]       p_out,
   input  logic             p_ready,
   output logic             busy
`ifdef PERC_CTRL_STATS_EN
   ,
   output logic [7:0]       cnt_circle,
   output logic [7:0]       cnt_cross,
   output logic [7:0]       cnt_none,
   output logic [7:0]       cnt_timeout
`endif
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    state;
   logic [1:0]    class_q;
   logic [TW-1:0] tmo;
   logic          beat;
   logic          done;

   assign beat = bus.pix_valid && bus.pix_ready;

   frame_deser #(.WIDTH(WIDTH)) u_deser (
      .clk    (clk),
      .rst_n  (rst_n),
      .bit_in (bus.pix_data),
      .beat   (beat),
      .frame  (p_in),
      .done   (done)
   );

   // Outputs decode straight from state so reset drops p_en at once.
   assign bus.pix_ready = (state == ST_LOAD);
   assign bus.res_valid = (state == ST_RESULT);
   assign bus.res_class = class_q;
   assign p_en          = (state == ST_RUN) || (state == ST_DRAIN);
   assign busy          = (state != ST_LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_LOAD;
         class_q <= CLASS_NONE;
         tmo     <= '0;
      end else begin
         unique case (state)
            ST_LOAD: begin
               tmo <= '0;
               if (done) state <= ST_RUN;
            end
            ST_RUN: begin
               if (p_ready) begin
                  class_q <= p_out;
                  tmo     <= '0;
                  state   <= ST_DRAIN;
               end else if (tmo == TW'(TIMEOUT - 1)) begin
                  class_q <= CLASS_TIMEOUT;
                  tmo     <= '0;
                  state   <= ST_DRAIN;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            ST_DRAIN: state <= ST_RESULT;
            ST_RESULT: begin
               if (bus.res_ack) state <= ST_LOAD;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

`ifdef PERC_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_circle  <= '0;
         cnt_cross   <= '0;
         cnt_none    <= '0;
         cnt_timeout <= '0;
      end else if (state == ST_DRAIN) begin
         unique case (class_q)
            CLASS_NONE:    cnt_none    <= sat_inc(cnt_none);
            CLASS_CIRCLE:  cnt_circle  <= sat_inc(cnt_circle);
            CLASS_CROSS:   cnt_cross   <= sat_inc(cnt_cross);
            CLASS_TIMEOUT: cnt_timeout <= sat_inc(cnt_timeout);
            default:       cnt_none    <= cnt_none;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_perceptron_frame_ctrl.sv
// Randomized self-checking bench for perceptron_frame_ctrl with a
// behavioural classifier stand-in of programmable latency and class code.
module tb_perceptron_frame_ctrl;

   localparam int W  = 25;
   localparam int TO = 64;

   localparam logic [W-1:0] CROSS_F  = W'((1 << 0) | (1 << 4) | (1 << 12) |
                                          (1 << 20) | (1 << 24));
   localparam logic [W-1:0] CIRCLE_F = W'((1 << 2) | (1 << 10) | (1 << 14) |
                                          (1 << 22));

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] p_in;
   logic         p_en;
   logic [1:0]   p_out;
   logic         p_ready;
   logic         busy;

   int           lat;
   logic [1:0]   code;
   logic [1:0]   junk;
   int           en_cnt;

   int           n_chk  = 0;
   int           n_pass = 0;
   int           mcnt [4];

   always #5 clk = ~clk;

   perceptron_frame_ctrl_if bus ();

`ifdef PERC_CTRL_STATS_EN
   logic [7:0] cnt_circle, cnt_cross, cnt_none, cnt_timeout;
`endif

   perceptron_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .p_in        (p_in),
      .p_en        (p_en),
      .p_out       (p_out),
      .p_ready     (p_ready),
      .busy        (busy)
`ifdef PERC_CTRL_STATS_EN
      ,
      .cnt_circle  (cnt_circle),
      .cnt_cross   (cnt_cross),
      .cnt_none    (cnt_none),
      .cnt_timeout (cnt_timeout)
`endif
   );

   // Classifier stand-in: pulses p_ready in its lat-th enabled cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)    en_cnt <= 0;
      else if (p_en) en_cnt <= en_cnt + 1;
      else           en_cnt <= 0;
   end

   always @(negedge clk) junk <= 2'($urandom);

   assign p_ready = p_en && (en_cnt == lat - 1);
   assign p_out   = p_ready ? code : junk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic send_beats(input logic [W-1:0] f);
      for (int i = 0; i < W; i++) begin
         int gap = $urandom_range(0, 2);
         repeat (gap) begin
            bus.pix_valid = 1'b0;
            bus.pix_data  = 1'($urandom);
            @(posedge clk); #1;
         end
         bus.pix_valid = 1'b1;
         bus.pix_data  = f[i];
         @(posedge clk); #1;
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic run_frame(input logic [W-1:0] f, input int l,
                            input logic [1:0] c, input int ack_dly);
      int         run_cyc;
      logic [1:0] exp_c;
      int         n;
      int         en_hi;
      bit         seen;
      lat     = l;
      code    = c;
      run_cyc = (l <= TO) ? l : TO;
      exp_c   = (l <= TO) ? c : 2'b11;
      send_beats(f);
      n     = 0;
      en_hi = 0;
      seen  = 0;
      while (n < 300 && !seen) begin
         @(negedge clk);
         n++;
         if (bus.res_valid) seen = 1;
         else if (p_en) en_hi++;
         if (n == 1)
            chk("run_entry", {p_in, p_en, busy, bus.pix_ready},
                {f, 1'b1, 1'b1, 1'b0});
         bus.pix_valid = 1'($urandom);
         bus.pix_data  = 1'($urandom);
      end
      chk("res_latency", 64'(n), 64'(run_cyc + 2));
      chk("en_cycles", 64'(en_hi), 64'(run_cyc + 1));
      chk("res_class", bus.res_class, exp_c);
      for (int k = 0; k < ack_dly; k++) begin
         @(negedge clk);
         chk("hold", {bus.res_valid, bus.res_class, bus.pix_ready, p_en, p_in},
             {1'b1, exp_c, 1'b0, 1'b0, f});
         bus.pix_valid = 1'($urandom);
         bus.pix_data  = 1'($urandom);
      end
      bus.res_ack = 1'b1;
      @(posedge clk); #1;
      bus.res_ack   = 1'b0;
      bus.pix_valid = 1'b0;
      @(negedge clk);
      chk("after_ack", {bus.pix_ready, bus.res_valid, busy},
          {1'b1, 1'b0, 1'b0});
      if (mcnt[exp_c] < 255) mcnt[exp_c]++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef PERC_CTRL_STATS_EN
   task automatic chk_stats(input string tag);
      chk(tag, {cnt_none, cnt_circle, cnt_cross, cnt_timeout},
          {8'(mcnt[0]), 8'(mcnt[1]), 8'(mcnt[2]), 8'(mcnt[3])});
   endtask
`endif

   initial begin
      rst_n         = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_data  = 1'b0;
      bus.res_ack   = 1'b0;
      lat           = 52;
      code          = 2'b00;
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      #12;
      chk("reset", {bus.pix_ready, p_en, bus.res_valid, bus.res_class,
                    busy, p_in},
          {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, {W{1'b0}}});
      @(negedge clk);
      rst_n = 1'b1;

      run_frame(CROSS_F, 52, 2'b10, 10);
      run_frame(CIRCLE_F, 52, 2'b01, 3);
      run_frame('0, 52, 2'b00, 0);
      run_frame(CROSS_F, 100000, 2'b10, 2);
      run_frame(CIRCLE_F, TO, 2'b01, 1);
      run_frame(CIRCLE_F, TO + 1, 2'b01, 1);
      run_frame(CROSS_F, 1, 2'b10, 0);

      for (int r = 0; r < 20; r++)
         run_frame(W'($urandom), $urandom_range(1, 80), 2'($urandom),
                   $urandom_range(0, 4));

      // Abort twenty cycles into RUN with an asynchronous reset.
      lat = 52;
      send_beats(CROSS_F);
      repeat (20) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_abort", {p_en, bus.res_valid, busy, bus.pix_ready, p_in},
          {1'b0, 1'b0, 1'b0, 1'b1, {W{1'b0}}});
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(CROSS_F, 52, 2'b10, 1);

`ifdef PERC_CTRL_STATS_EN
      do_reset();
      chk_stats("stats_zero");
      for (int i = 0; i < 3; i++) run_frame(CROSS_F, 52, 2'b10, 0);
      for (int i = 0; i < 2; i++) run_frame(CIRCLE_F, 52, 2'b01, 0);
      run_frame('0, 100000, 2'b00, 0);
      chk_stats("stats_mix");
      for (int i = 0; i < 300; i++) run_frame(CROSS_F, 1, 2'b10, 0);
      chk_stats("stats_sat");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
